// File: rtl/fsm_seek_bit_tx.sv
// Serial bit-stream transmitter feeding the x input of the seek/detect FSM.
// Parallel words arrive over valid/ready and go out MSB-first, one bit per
// clock, with an optional idle gap after each word and a saturating count of
// words fully sent.
module fsm_seek_bit_tx #(
    parameter int   DATA_W     = 8,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_BIT   = 1'b0,
    parameter int   CNT_W      = 16,
    localparam int  LEN_W      = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [LEN_W-1:0]  in_len,
    output logic              x,
    output logic              x_valid,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sent_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DATA_W);
    localparam logic [7:0]       GAP_LOAD = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t              state;
    logic [DATA_W-1:0]   sh;
    logic [LEN_W-1:0]    bitcnt;
    logic [7:0]          gapcnt;

    logic                last;
    logic                accept;
    logic [LEN_W-1:0]    eff_len;
    logic [DATA_W-1:0]   aligned;

    // A zero or oversize length means "send the whole word".
    function automatic logic [LEN_W-1:0] effective_len(input logic [LEN_W-1:0] len);
        if ((len == '0) || (len > FULL_LEN)) begin
            return FULL_LEN;
        end
        return len;
    endfunction

    // Handshake, last-bit detection and left-alignment of the incoming word.
    always_comb begin
        last     = (bitcnt == '0);
        in_ready = (state == IDLE) ||
                   ((state == SHIFT) && last && (GAP_CYCLES == 0));
        accept   = in_valid && in_ready;
        eff_len  = effective_len(in_len);
        aligned  = in_data << (FULL_LEN - eff_len);
        busy     = (state != IDLE);
    end

    // Single FSM: state, shift register, counters and registered outputs.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            sh       <= '0;
            bitcnt   <= '0;
            gapcnt   <= '0;
            x        <= IDLE_BIT;
            x_valid  <= 1'b0;
            done     <= 1'b0;
            sent_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= SHIFT;
                        sh      <= aligned;
                        bitcnt  <= eff_len - 1'b1;
                        x       <= aligned[DATA_W-1];
                        x_valid <= 1'b1;
                        done    <= (eff_len == LEN_W'(1));
                    end else begin
                        x       <= IDLE_BIT;
                        x_valid <= 1'b0;
                        done    <= 1'b0;
                    end
                end

                SHIFT: begin
                    if (!last) begin
                        // x already shows sh's MSB; present the next one.
                        sh      <= sh << 1;
                        bitcnt  <= bitcnt - 1'b1;
                        x       <= sh[DATA_W-2];
                        x_valid <= 1'b1;
                        done    <= (bitcnt == LEN_W'(1));
                    end else begin
                        if (sent_cnt != '1) begin
                            sent_cnt <= sent_cnt + 1'b1;
                        end
                        if (GAP_CYCLES > 0) begin
                            state   <= GAP;
                            gapcnt  <= GAP_LOAD;
                            x       <= IDLE_BIT;
                            x_valid <= 1'b0;
                            done    <= 1'b0;
                        end else if (accept) begin
                            // Back-to-back word: no bubble on x.
                            sh      <= aligned;
                            bitcnt  <= eff_len - 1'b1;
                            x       <= aligned[DATA_W-1];
                            x_valid <= 1'b1;
                            done    <= (eff_len == LEN_W'(1));
                        end else begin
                            state   <= IDLE;
                            x       <= IDLE_BIT;
                            x_valid <= 1'b0;
                            done    <= 1'b0;
                        end
                    end
                end

                GAP: begin
                    x       <= IDLE_BIT;
                    x_valid <= 1'b0;
                    done    <= 1'b0;
                    if (gapcnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gapcnt <= gapcnt - 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    x       <= IDLE_BIT;
                    x_valid <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_seek_bit_tx.sv
// Bench for fsm_seek_bit_tx: one instance with no gap (idle bit 0) and one
// with a 3-cycle gap, idle bit 1 and a 2-bit saturating word counter.
module tb_fsm_seek_bit_tx;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;

    logic        v0 = 1'b0, r0, x0, xv0, b0, dn0;
    logic [7:0]  d0 = '0;
    logic [3:0]  l0 = '0;
    logic [15:0] c0;

    logic        v3 = 1'b0, r3, x3, xv3, b3, dn3;
    logic [7:0]  d3 = '0;
    logic [3:0]  l3 = '0;
    logic [1:0]  c3;

    int checks = 0;
    int errors = 0;
    int exp_cnt0 = 0;
    int exp_cnt3 = 0;

    typedef struct {
        logic [7:0] data;
        logic [3:0] len;
        logic [7:0] bits;
        int         n;
    } vec_t;

    vec_t vecs[6];

    fsm_seek_bit_tx #(.DATA_W(8), .GAP_CYCLES(0), .IDLE_BIT(1'b0), .CNT_W(16)) dut0 (
        .clk(clk), .aresetn(aresetn), .in_valid(v0), .in_ready(r0),
        .in_data(d0), .in_len(l0), .x(x0), .x_valid(xv0), .busy(b0),
        .done(dn0), .sent_cnt(c0)
    );

    fsm_seek_bit_tx #(.DATA_W(8), .GAP_CYCLES(3), .IDLE_BIT(1'b1), .CNT_W(2)) dut3 (
        .clk(clk), .aresetn(aresetn), .in_valid(v3), .in_ready(r3),
        .in_data(d3), .in_len(l3), .x(x3), .x_valid(xv3), .busy(b3),
        .done(dn3), .sent_cnt(c3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Source rule: data must hold while a word is offered but not taken.
    logic       pv0 = 1'b0, pr0 = 1'b0, pv3 = 1'b0, pr3 = 1'b0;
    logic [7:0] pd0 = '0, pd3 = '0;
    always @(posedge clk) begin
        if (aresetn) begin
            if (pv0 && !pr0 && (d0 !== pd0)) begin
                errors++;
                $display("FAIL src_stable0: got %0h expected %0h", d0, pd0);
            end
            if (pv3 && !pr3 && (d3 !== pd3)) begin
                errors++;
                $display("FAIL src_stable3: got %0h expected %0h", d3, pd3);
            end
        end
        pv0 <= v0; pr0 <= r0; pd0 <= d0;
        pv3 <= v3; pr3 <= r3; pd3 <= d3;
    end

    // Outputs must be known whenever reset is released.
    always @(negedge clk) begin
        if (aresetn && $isunknown({x0, xv0, dn0, r0, x3, xv3, dn3, r3})) begin
            errors++;
            $display("FAIL xcheck: got %b expected no X", {x0, xv0, dn0, r0, x3, xv3, dn3, r3});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Send one word on the no-gap instance and check every bit.
    task automatic send0(input logic [7:0] data, input logic [3:0] len,
                         input logic [7:0] bits, input int n);
        @(negedge clk);
        chk("rdy0_idle", r0, 1);
        d0 = data; l0 = len; v0 = 1'b1;
        @(posedge clk);
        #1 v0 = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("x0_bit", x0, bits[n-1-i]);
            chk("xv0_bit", xv0, 1);
            chk("done0", dn0, (i == n - 1));
            if (i == n - 1) chk("cnt0_last", c0, exp_cnt0);
        end
        @(negedge clk);
        exp_cnt0++;
        chk("xv0_after", xv0, 0);
        chk("x0_after", x0, 0);
        chk("busy0_after", b0, 0);
        chk("cnt0_after", c0, exp_cnt0);
    endtask

    // Send a one-bit word on the gap instance, then walk through the gap.
    task automatic send3_short();
        @(negedge clk);
        chk("rdy3_idle", r3, 1);
        d3 = 8'h01; l3 = 4'd1; v3 = 1'b1;
        @(posedge clk);
        #1 v3 = 1'b0;
        @(negedge clk);
        chk("x3_short", x3, 1);
        chk("xv3_short", xv3, 1);
        chk("done3_short", dn3, 1);
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            chk("xv3_sgap", xv3, 0);
            chk("rdy3_sgap", r3, 0);
        end
        @(negedge clk);
        exp_cnt3 = (exp_cnt3 == 3) ? 3 : exp_cnt3 + 1;
        chk("busy3_sidle", b3, 0);
        chk("cnt3_sat", c3, exp_cnt3);
    endtask

    initial begin
        vecs[0] = '{8'hB2, 4'd8, 8'hB2, 8};
        vecs[1] = '{8'hF5, 4'd3, 8'h05, 3};
        vecs[2] = '{8'hC3, 4'd0, 8'hC3, 8};
        vecs[3] = '{8'h5A, 4'd9, 8'h5A, 8};
        vecs[4] = '{8'h01, 4'd1, 8'h01, 1};
        vecs[5] = '{8'h80, 4'd1, 8'h00, 1};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_x0", x0, 0);
        chk("rst_xv0", xv0, 0);
        chk("rst_done0", dn0, 0);
        chk("rst_busy0", b0, 0);
        chk("rst_cnt0", c0, 0);
        chk("rst_rdy0", r0, 1);
        chk("rst_x3", x3, 1);
        chk("rst_cnt3", c3, 0);
        aresetn = 1'b1;

        // Table-driven single words
        for (int k = 0; k < 6; k++) begin
            send0(vecs[k].data, vecs[k].len, vecs[k].bits, vecs[k].n);
        end

        // Back-to-back A5 then 3C with valid held
        begin
            logic [15:0] bb;
            bb = 16'hA53C;
            @(negedge clk);
            d0 = 8'hA5; l0 = 4'd8; v0 = 1'b1;
            @(posedge clk);
            #1 d0 = 8'h3C;
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                chk("bb_x", x0, bb[15-i]);
                chk("bb_xv", xv0, 1);
                chk("bb_done", dn0, (i == 7) || (i == 15));
                if (i == 3) chk("bb_rdy_mid", r0, 0);
                if (i == 7) begin
                    chk("bb_rdy_last", r0, 1);
                    @(posedge clk);
                    #1 v0 = 1'b0;
                end
                if (i == 8) chk("bb_cnt_mid", c0, exp_cnt0 + 1);
            end
            @(negedge clk);
            exp_cnt0 += 2;
            chk("bb_xv_end", xv0, 0);
            chk("bb_cnt_end", c0, exp_cnt0);
        end

        // Reset mid-word after the 4th bit of B2
        @(negedge clk);
        d0 = 8'hB2; l0 = 4'd8; v0 = 1'b1;
        @(posedge clk);
        #1 v0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rm_x", x0, (8'hB2 >> (7 - i)) & 8'h01);
        end
        #2 aresetn = 1'b0;
        #1;
        chk("rm_x0", x0, 0);
        chk("rm_xv0", xv0, 0);
        chk("rm_busy0", b0, 0);
        chk("rm_cnt0", c0, 0);
        chk("rm_done0", dn0, 0);
        chk("rm_rdy0", r0, 1);
        @(negedge clk);
        aresetn = 1'b1;
        exp_cnt0 = 0;
        exp_cnt3 = 0;
        send0(8'h81, 4'd8, 8'h81, 8);

        // Gap insertion: two FF words with valid held through the gap
        @(negedge clk);
        chk("gap_rdy_idle", r3, 1);
        d3 = 8'hFF; l3 = 4'd8; v3 = 1'b1;
        @(posedge clk);
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                chk("gap_x", x3, 1);
                chk("gap_xv", xv3, 1);
                chk("gap_rdy_shift", r3, 0);
                chk("gap_done", dn3, (i == 7));
            end
            for (int g = 0; g < 3; g++) begin
                @(negedge clk);
                chk("gap_xv_gap", xv3, 0);
                chk("gap_x_gap", x3, 1);
                chk("gap_rdy_gap", r3, 0);
                chk("gap_busy_gap", b3, 1);
            end
            @(negedge clk);
            exp_cnt3++;
            chk("gap_busy_idle", b3, 0);
            chk("gap_rdy_idle2", r3, 1);
            chk("gap_cnt", c3, exp_cnt3);
            if (w == 0) begin
                @(posedge clk);
                #1 v3 = 1'b0;
            end
        end

        // Counter saturation on the 2-bit instance
        send3_short();
        send3_short();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
